// File: rtl/uart_rx_path_if.sv
// Serial receive link bundle: the line going into the receiver, and the word
// and status strobes coming out of it.
`timescale 1ns/1ps
interface uart_rx_path_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    output rx_in,
    input  rx_data, rx_valid, frame_err, rx_busy
  );

  modport slave (
    input  rx_in,
    output rx_data, rx_valid, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_path.sv
// UART receiver: synchronises rx_in, finds the start bit, samples each bit at
// mid-bit with a divided bit timer, and strobes out good words or framing errors.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synced line
// START | counting half a bit to re-check the start bit at its centre
// DATA  | sampling data bits at mid-bit, LSB first
// STOP  | sampling the stop bit; high = good word, low = framing error
// BREAK | line held low after a bad stop bit; wait for it to go high
`timescale 1ns/1ps
module uart_rx_path #(
  parameter int BAUD_DIV  = 868,
  parameter int DATA_BITS = 8
) (
  input logic           clk,
  input logic           reset,
  uart_rx_path_if.slave rx
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_MID  = BW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta, rx_s;
  logic [BW-1:0]        baud_cnt_q, baud_cnt_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 tick;

  // Synchroniser resets to the idle-line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx.rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign tick = (baud_cnt_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        if (baud_cnt_q == BAUD_MID) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = rx_s ? IDLE : DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (tick) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (tick) begin
          baud_cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      // Only a return to high re-arms the receiver, so a held-low line is one error.
      BREAK: begin
        baud_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_path.sv
// Bench for uart_rx_path: directed frames, expected strobes queued at send time
// and matched by a monitor whenever rx_valid or frame_err fires.
`timescale 1ns/1ps
module tb_uart_rx_path;

  localparam int BAUD_DIV  = 16;
  localparam int DATA_BITS = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  uart_rx_path_if #(.DATA_BITS(DATA_BITS)) rx_if ();

  uart_rx_path #(
    .BAUD_DIV (BAUD_DIV),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx_if)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && (rx_if.rx_valid || rx_if.frame_err)) begin
      if (rx_if.rx_valid && rx_if.frame_err) begin
        check("valid_err_overlap", {30'd0, rx_if.rx_valid, rx_if.frame_err}, 32'd2);
      end else if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, rx_if.rx_valid, rx_if.frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check(e.is_err ? "err_strobe_kind" : "valid_strobe_kind",
              {31'd0, rx_if.frame_err}, {31'd0, e.is_err});
        check(e.is_err ? "rx_data_held" : "rx_data", {24'd0, rx_if.rx_data}, {24'd0, e.data});
      end
    end
  end

  // All stimulus changes 1 ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // t10 is the bit period in tenths of a clock, so bit lengths can be fractional.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int t10);
    int         cyc  = 0;
    logic [9:0] bits = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_if.rx_in = bits[k];
      while (cyc < ((k + 1) * t10 + 5) / 10) begin
        @(posedge clk);
        cyc++;
      end
      #1;
    end
  endtask

  task automatic push(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_valid"},  {31'd0, rx_if.rx_valid},  32'd0);
    check({tag, "_frame_err"}, {31'd0, rx_if.frame_err}, 32'd0);
    check({tag, "_rx_busy"},   {31'd0, rx_if.rx_busy},   32'd0);
    check({tag, "_rx_data"},   {24'd0, rx_if.rx_data},   32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got %0t ns, limit 300000 ns", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.rx_in = 1'b1;
    reset       = 1'b1;
    idle(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle(5);

    // Single good frame
    push(1'b0, 8'hA5);
    send_frame(8'hA5, 1'b1, 160);
    idle(20);

    // Short low glitch must be rejected at the mid-start check
    rx_if.rx_in = 1'b0;
    idle(4);
    rx_if.rx_in = 1'b1;
    idle(1);
    check("glitch_busy_high", {31'd0, rx_if.rx_busy}, 32'd1);
    idle(7);
    check("glitch_busy_clear", {31'd0, rx_if.rx_busy}, 32'd0);
    idle(20);

    // Bad stop bit, then a long low line, then recovery
    push(1'b1, 8'hA5);
    send_frame(8'h3C, 1'b0, 160);
    idle(40);
    check("break_busy", {31'd0, rx_if.rx_busy}, 32'd1);
    rx_if.rx_in = 1'b1;
    idle(20);
    push(1'b0, 8'h55);
    send_frame(8'h55, 1'b1, 160);
    idle(20);

    // Back-to-back frames with a single stop bit
    push(1'b0, 8'h00);
    push(1'b0, 8'hFF);
    send_frame(8'h00, 1'b1, 160);
    send_frame(8'hFF, 1'b1, 160);
    idle(20);

    // Reset in the middle of data bit 3; line finishes the frame under reset
    fork
      send_frame(8'h81, 1'b1, 160);
      begin
        repeat (70) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midframe_reset");
      end
    join
    idle(5);
    reset = 1'b0;
    idle(20);
    push(1'b0, 8'h81);
    send_frame(8'h81, 1'b1, 160);
    idle(20);

    // Bit rate off by +5% and -5%
    push(1'b0, 8'h6E);
    send_frame(8'h6E, 1'b1, 168);
    idle(20);
    push(1'b0, 8'h6E);
    send_frame(8'h6E, 1'b1, 152);
    idle(20);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, rx_if.rx_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
